memory_access_unit: RTL and testbench
=====================================

// Module: memory_access_unit
// PURPOSE
//  Memory-stage data-memory initiator. Takes the executing instruction's address and store data.
//  Runs one load or store handshake on the data-memory port.
//  Returns the aligned, extended load value M_valM_o and the stage-done flag memory_ready_o.
//  memory_reg consumes both; it latches when memory_ready & write_back_allow_in are both high.
// PARAMETERS
//  XLEN        `XLEN (32)  data width, byte-addressed; only 32 is supported
//  ADDR_WIDTH  32          data-memory address width
// PORTS
//  clk_i                  in   1          single clock, all state on posedge
//  rst                    in   1          synchronous, active-high reset
//  execute_vaild_i        in   1          ED stage holds a valid instruction
//  ED_mem_rd_i            in   1          instruction is a load
//  ED_mem_wr_i            in   1          instruction is a store
//  ED_mem_op_i            in   3          funct3: LB/SB=000 LH/SH=001 LW/SW=010 LBU=100 LHU=101
//  ED_valE_i              in   XLEN       effective address
//  ED_valB_i              in   XLEN       store data (rs2)
//  write_back_allow_in_i  in   1          write-back stage accepts this cycle
//  memory_ready_o         out  1          M result valid / stage may advance
//  M_valM_o               out  XLEN       load result, extended to XLEN; 0 for stores
//  dmem_req_o             out  1          request valid
//  dmem_we_o              out  1          1 = write
//  dmem_addr_o            out  ADDR_WIDTH word-aligned address ({addr[31:2],2'b00})
//  dmem_wstrb_o           out  4          byte write strobes
//  dmem_wdata_o           out  XLEN       lane-replicated store data
//  dmem_gnt_i             in   1          request accepted this cycle
//  dmem_rvalid_i          in   1          response (read data or write ack), at least 1 cycle after gnt
//  dmem_rdata_i           in   XLEN       read data, valid with rvalid
// BEHAVIOUR
//  FSM states: IDLE, REQ, WAIT, DONE. Reset values: state=IDLE, rdata_q=0, op_q=0, off_q=0.
//  memop = execute_vaild_i & (ED_mem_rd_i | ED_mem_wr_i).
//  IDLE:
//   - memop=0: memory_ready_o=1 and M_valM_o=0; the stage is a pass-through.
//   - memop=1: dmem_req_o=1 in the same cycle; latch op_q and off_q=addr[1:0].
//   - gnt -> WAIT, else -> REQ.
//  REQ: hold dmem_req_o=1; all request fields come from the ED inputs, which are stable while not ready.
//   - gnt -> WAIT.
//  WAIT: dmem_req_o=0. On rvalid, capture rdata_q, then -> DONE.
//  DONE:
//   - memory_ready_o=1; M_valM_o is extracted from rdata_q.
//   - write_back_allow_in_i=1 -> IDLE, and the next instruction may issue the following cycle.
//   - otherwise hold DONE with the output stable.
//  memory_ready_o=0 in REQ/WAIT. Minimum load/store latency: issue cycle + 1 response cycle + DONE.
//  Store lanes:
//   - SB: wstrb=1<<off, wdata={4{b}}
//   - SH: wstrb=off[1]?1100:0011, wdata={2{h}}
//   - SW: wstrb=1111
//  Load extraction: byte/half selected by off_q. LB/LH sign-extend; LBU/LHU zero-extend.
//  Stores: M_valM_o=0.
//  Any response arriving in IDLE/REQ/DONE is ignored. The transaction in WAIT is never cancelled.
//  execute_vaild_i falling in REQ/WAIT does not abort; completion proceeds normally.
//  rst in any state -> IDLE next edge, request dropped; the memory must tolerate an orphaned response.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined:
//   - LH/SH with off[0]=1 or LW/SW with off!=0 issues no request.
//   - Goes straight to DONE with M_misalign_o=1 (extra 1-bit output, reset 0) and M_valM_o=0.
//  MISALIGN_TRAP_EN undefined: offset bits below the access size are forced to 0 (natural alignment).
// STRUCTURE
//  Shared package/define.v: `XLEN, funct3 load/store encodings, FSM state encodings.
//  One sub-module: mem_lane_align.
//   - Combinational; handles store strobe/replication and load extract/extend.
//   - Reused by a future instruction-fetch path.
// TESTING
//  - LW @0x100, gnt same cycle, rvalid +2 cycles with 0xDEADBEEF -> ready after 3 cycles, M_valM=0xDEADBEEF.
//  - LB @0x103, rdata 0x80FF_1234 -> M_valM=0xFFFFFF80; LBU -> 0x00000080; LHU @0x102 -> 0x000080FF.
//  - SH @0x202, data 0x1234ABCD -> we=1, wstrb=1100, wdata=0xABCDABCD, addr=0x200; ready after ack.
//  - gnt held low 4 cycles -> req stays high with stable addr; DONE with wb_allow_in=0 for 3 cycles holds M_valM.
//  - Non-memory instruction (ALU) -> no dmem_req, memory_ready=1 in the same cycle.
//  - rst asserted in WAIT -> IDLE next cycle, later stray rvalid ignored; with MISALIGN_TRAP_EN, LW @0x101 -> no req, misalign=1.

Source files
------------

// File: rtl/memory_access_unit_pkg.sv
// Shared definitions for the memory-stage data-memory initiator.
//  - MAU_XLEN / MAU_ADDR_W : data and address widths (only 32 is supported)
//  - F3_*                  : funct3 encodings for loads and stores
//  - mau_state_e           : FSM state encoding
//  - natural_off()         : forces offset bits below the access size to zero
//  - is_misaligned()       : detects an offset that is not size-aligned
package memory_access_unit_pkg;

    localparam int MAU_XLEN   = 32;
    localparam int MAU_ADDR_W = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } mau_state_e;

    // funct3[1:0] encodes the access size: 00 byte, 01 half, 1x word.
    function automatic logic [1:0] natural_off(input logic [2:0] op, input logic [1:0] off);
        case (op[1:0])
            2'b00:   natural_off = off;
            2'b01:   natural_off = {off[1], 1'b0};
            default: natural_off = 2'b00;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] off);
        case (op[1:0])
            2'b00:   is_misaligned = 1'b0;
            2'b01:   is_misaligned = off[0];
            default: is_misaligned = (off != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/memory_access_unit_mem_lane_align.sv
// mem_lane_align: combinational byte-lane steering for a 32-bit data port.
//  Store side: byte strobes and lane-replicated write data for SB/SH/SW.
//  Load side : byte/half extraction with sign or zero extension.
// Ports:
//  i_op       funct3 of the access
//  i_off      byte offset within the word (already size-aligned by the caller)
//  i_st_data  store source data
//  i_ld_data  raw word read from memory
//  o_wstrb    byte write strobes
//  o_wdata    lane-replicated write data
//  o_ld_val   extracted and extended load value
module mem_lane_align
    import memory_access_unit_pkg::*;
#(
    parameter int XLEN = MAU_XLEN
) (
    input  logic [2:0]      i_op,
    input  logic [1:0]      i_off,
    input  logic [XLEN-1:0] i_st_data,
    input  logic [XLEN-1:0] i_ld_data,
    output logic [3:0]      o_wstrb,
    output logic [XLEN-1:0] o_wdata,
    output logic [XLEN-1:0] o_ld_val
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_wstrb = 4'b1111;
        o_wdata = i_st_data;
        case (i_op[1:0])
            2'b00: begin
                o_wstrb = 4'b0001 << i_off;
                o_wdata = {4{i_st_data[7:0]}};
            end
            2'b01: begin
                o_wstrb = i_off[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_st_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_byte = i_ld_data[{i_off, 3'b000} +: 8];
        w_half = i_off[1] ? i_ld_data[31:16] : i_ld_data[15:0];
        case (i_op)
            F3_B:    o_ld_val = {{(XLEN-8){w_byte[7]}}, w_byte};
            F3_BU:   o_ld_val = {{(XLEN-8){1'b0}}, w_byte};
            F3_H:    o_ld_val = {{(XLEN-16){w_half[15]}}, w_half};
            F3_HU:   o_ld_val = {{(XLEN-16){1'b0}}, w_half};
            default: o_ld_val = i_ld_data;
        endcase
    end

endmodule

// File: rtl/memory_access_unit.sv
// memory_access_unit: memory-stage data-memory initiator.
//  Issues one load or store request per memory instruction, waits for the
//  response, and presents the aligned/extended load value with memory_ready_o.
//  Non-memory instructions pass straight through with memory_ready_o=1.
// Optional feature: define MISALIGN_TRAP_EN to trap size-misaligned accesses
//  (no request, straight to DONE with M_misalign_o=1). Without it, offset bits
//  below the access size are ignored.
// Ports:
//  clk_i, rst                      clock, synchronous active-high reset
//  execute_vaild_i, ED_mem_rd_i,
//  ED_mem_wr_i, ED_mem_op_i,
//  ED_valE_i, ED_valB_i            instruction from the execute stage
//  write_back_allow_in_i           write-back stage accepts the result
//  memory_ready_o, M_valM_o        stage done flag and load result
//  M_misalign_o                    misalignment trap flag (MISALIGN_TRAP_EN only)
//  dmem_*                          data-memory request/response port
module memory_access_unit
    import memory_access_unit_pkg::*;
#(
    parameter int XLEN       = MAU_XLEN,
    parameter int ADDR_WIDTH = MAU_ADDR_W
) (
    input  logic                  clk_i,
    input  logic                  rst,
    input  logic                  execute_vaild_i,
    input  logic                  ED_mem_rd_i,
    input  logic                  ED_mem_wr_i,
    input  logic [2:0]            ED_mem_op_i,
    input  logic [XLEN-1:0]       ED_valE_i,
    input  logic [XLEN-1:0]       ED_valB_i,
    input  logic                  write_back_allow_in_i,
`ifdef MISALIGN_TRAP_EN
    output logic                  M_misalign_o,
`endif
    output logic                  memory_ready_o,
    output logic [XLEN-1:0]       M_valM_o,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [ADDR_WIDTH-1:0] dmem_addr_o,
    output logic [3:0]            dmem_wstrb_o,
    output logic [XLEN-1:0]       dmem_wdata_o,
    input  logic                  dmem_gnt_i,
    input  logic                  dmem_rvalid_i,
    input  logic [XLEN-1:0]       dmem_rdata_i
);

    mau_state_e      r_state;
    logic [XLEN-1:0] r_rdata_q;
    logic [2:0]      r_op_q;
    logic [1:0]      r_off_q;
    logic            r_is_load;
`ifdef MISALIGN_TRAP_EN
    logic            r_misalign;
`endif

    logic            w_memop;
    logic            w_trap;
    logic [1:0]      w_off_nat;
    logic            w_in_done;
    logic [2:0]      w_lane_op;
    logic [1:0]      w_lane_off;
    logic [3:0]      w_wstrb;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_ld_val;

    assign w_memop   = execute_vaild_i & (ED_mem_rd_i | ED_mem_wr_i);
    assign w_off_nat = natural_off(ED_mem_op_i, ED_valE_i[1:0]);
`ifdef MISALIGN_TRAP_EN
    assign w_trap    = is_misaligned(ED_mem_op_i, ED_valE_i[1:0]);
`else
    assign w_trap    = 1'b0;
`endif

    // One lane aligner serves both directions: request fields only matter in
    // IDLE/REQ (driven from ED), load extraction only in DONE (driven from the
    // latched op/offset).
    assign w_in_done  = (r_state == ST_DONE);
    assign w_lane_op  = w_in_done ? r_op_q  : ED_mem_op_i;
    assign w_lane_off = w_in_done ? r_off_q : w_off_nat;

    mem_lane_align #(.XLEN(XLEN)) u_lane_align (
        .i_op      (w_lane_op),
        .i_off     (w_lane_off),
        .i_st_data (ED_valB_i),
        .i_ld_data (r_rdata_q),
        .o_wstrb   (w_wstrb),
        .o_wdata   (w_wdata),
        .o_ld_val  (w_ld_val)
    );

    always_ff @(posedge clk_i) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_rdata_q <= '0;
            r_op_q    <= '0;
            r_off_q   <= '0;
            r_is_load <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            r_misalign <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_memop) begin
                        r_op_q    <= ED_mem_op_i;
                        r_off_q   <= w_off_nat;
                        r_is_load <= ED_mem_rd_i & ~w_trap;
                        if (w_trap) begin
                            r_state <= ST_DONE;
`ifdef MISALIGN_TRAP_EN
                            r_misalign <= 1'b1;
`endif
                        end else if (dmem_gnt_i) begin
                            r_state <= ST_WAIT;
                        end else begin
                            r_state <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (dmem_gnt_i) r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (dmem_rvalid_i) begin
                        r_rdata_q <= dmem_rdata_i;
                        r_state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (write_back_allow_in_i) begin
                        r_state <= ST_IDLE;
`ifdef MISALIGN_TRAP_EN
                        r_misalign <= 1'b0;
`endif
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // The request is raised combinationally in IDLE so a granted access costs
    // no extra cycle; it is masked during reset so nothing new is issued.
    assign dmem_req_o = ~rst & (((r_state == ST_IDLE) & w_memop & ~w_trap) |
                                (r_state == ST_REQ));
    assign dmem_we_o    = ED_mem_wr_i;
    assign dmem_addr_o  = {ED_valE_i[ADDR_WIDTH-1:2], 2'b00};
    assign dmem_wstrb_o = ED_mem_wr_i ? w_wstrb : 4'b0000;
    assign dmem_wdata_o = w_wdata;

    assign memory_ready_o = ((r_state == ST_IDLE) & ~w_memop) | w_in_done;
    assign M_valM_o       = (w_in_done & r_is_load) ? w_ld_val : '0;
`ifdef MISALIGN_TRAP_EN
    assign M_misalign_o   = r_misalign;
`endif

endmodule

// File: tb/tb_memory_access_unit.sv
module tb_memory_access_unit;

    logic        clk_i = 1'b0;
    logic        rst;
    logic        execute_vaild_i, ED_mem_rd_i, ED_mem_wr_i;
    logic [2:0]  ED_mem_op_i;
    logic [31:0] ED_valE_i, ED_valB_i;
    logic        write_back_allow_in_i;
    logic        memory_ready_o;
    logic [31:0] M_valM_o;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_wstrb_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i, dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
`ifdef MISALIGN_TRAP_EN
    logic        M_misalign_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // observations from the last access
    int          obs_lat, obs_nreq;
    bit          obs_first_req, obs_req_stable, obs_hold_stable, obs_timeout;
    logic [31:0] obs_valM, obs_addr, obs_wdata;
    logic [3:0]  obs_strb;
    logic        obs_we, obs_mis;

    always #5 clk_i = ~clk_i;

    memory_access_unit dut (
        .clk_i                 (clk_i),
        .rst                   (rst),
        .execute_vaild_i       (execute_vaild_i),
        .ED_mem_rd_i           (ED_mem_rd_i),
        .ED_mem_wr_i           (ED_mem_wr_i),
        .ED_mem_op_i           (ED_mem_op_i),
        .ED_valE_i             (ED_valE_i),
        .ED_valB_i             (ED_valB_i),
        .write_back_allow_in_i (write_back_allow_in_i),
`ifdef MISALIGN_TRAP_EN
        .M_misalign_o          (M_misalign_o),
`endif
        .memory_ready_o        (memory_ready_o),
        .M_valM_o              (M_valM_o),
        .dmem_req_o            (dmem_req_o),
        .dmem_we_o             (dmem_we_o),
        .dmem_addr_o           (dmem_addr_o),
        .dmem_wstrb_o          (dmem_wstrb_o),
        .dmem_wdata_o          (dmem_wdata_o),
        .dmem_gnt_i            (dmem_gnt_i),
        .dmem_rvalid_i         (dmem_rvalid_i),
        .dmem_rdata_i          (dmem_rdata_i)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int access_size(input logic [2:0] op);
        case (op)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic int eff_off(input logic [2:0] op, input logic [31:0] addr);
        int sz, off;
        sz  = access_size(op);
        off = int'(addr % 4);
        return off - (off % sz);
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] op, input logic [31:0] addr,
                                             input logic [31:0] rd);
        int sz, off;
        longint v;
        sz  = access_size(op);
        off = eff_off(op, addr);
        v   = longint'(rd >> (8 * off)) & ((64'd1 << (8 * sz)) - 1);
        if (op < 3'b100 && sz < 4 && v >= longint'(64'd1 << (8 * sz - 1)))
            v = v - longint'(64'd1 << (8 * sz));
        return v[31:0];
    endfunction

    function automatic logic [3:0] exp_strb(input logic [2:0] op, input logic [31:0] addr);
        int sz;
        sz = access_size(op);
        return 4'(((1 << sz) - 1) << eff_off(op, addr));
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] op, input logic [31:0] d);
        logic [31:0] r;
        int sz;
        sz = access_size(op);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % sz) +: 8];
        return r;
    endfunction

    // ---------------- driver / memory responder ----------------
    task automatic run_op(input logic rd, input logic wr, input logic [2:0] op,
                          input logic [31:0] addr, input logic [31:0] data,
                          input int gnt_dly, input int rv_dly,
                          input logic [31:0] rdata, input int hold);
        int c, g_cycle;
        bit granted, done;
        obs_nreq = 0; obs_first_req = 0; obs_req_stable = 1; obs_hold_stable = 1;
        obs_timeout = 0; obs_lat = -1; obs_valM = 'x; obs_mis = 1'b0;
        obs_addr = 'x; obs_wdata = 'x; obs_strb = 'x; obs_we = 1'bx;
        execute_vaild_i = 1'b1; ED_mem_rd_i = rd; ED_mem_wr_i = wr;
        ED_mem_op_i = op; ED_valE_i = addr; ED_valB_i = data;
        write_back_allow_in_i = 1'b0;
        c = 0; g_cycle = 0; granted = 0; done = 0;
        while (!done && c < 200) begin
            @(negedge clk_i);
            if (memory_ready_o) begin
                obs_lat  = c;
                obs_valM = M_valM_o;
`ifdef MISALIGN_TRAP_EN
                obs_mis  = M_misalign_o;
`endif
                done = 1;
            end else begin
                if (c == 0) obs_first_req = dmem_req_o;
                if (dmem_req_o) begin
                    if (obs_nreq == 0) begin
                        obs_addr = dmem_addr_o; obs_wdata = dmem_wdata_o;
                        obs_strb = dmem_wstrb_o; obs_we = dmem_we_o;
                    end else if (dmem_addr_o !== obs_addr || dmem_wdata_o !== obs_wdata ||
                                 dmem_wstrb_o !== obs_strb || dmem_we_o !== obs_we) begin
                        obs_req_stable = 0;
                    end
                    obs_nreq++;
                    if (c >= gnt_dly) begin
                        dmem_gnt_i = 1'b1; granted = 1; g_cycle = c;
                    end
                end else if (granted && c == g_cycle + rv_dly) begin
                    dmem_rvalid_i = 1'b1; dmem_rdata_i = rdata;
                end
                @(posedge clk_i); #1;
                dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = $urandom;
                c++;
            end
        end
        if (!done) begin
            obs_timeout = 1;
        end else begin
            for (int h = 0; h < hold; h++) begin
                @(posedge clk_i); @(negedge clk_i);
                if (memory_ready_o !== 1'b1 || M_valM_o !== obs_valM) obs_hold_stable = 0;
            end
            write_back_allow_in_i = 1'b1;
            @(posedge clk_i); #1;
            execute_vaild_i = 1'b0; ED_mem_rd_i = 1'b0; ED_mem_wr_i = 1'b0;
            write_back_allow_in_i = 1'b0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 rst = 1'b0;
        @(negedge clk_i);
        n_tests++;
        if (memory_ready_o !== 1'b1 || dmem_req_o !== 1'b0 || M_valM_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_idle: ready=%b req=%b valM=%h, required ready=1 req=0 valM=0",
                     memory_ready_o, dmem_req_o, M_valM_o);
        end
    endtask

    task automatic test_passthrough();
        @(posedge clk_i); #1;
        execute_vaild_i = 1'b1; ED_mem_rd_i = 1'b0; ED_mem_wr_i = 1'b0;
        ED_valE_i = 32'h1234_5678; ED_mem_op_i = 3'b010;
        @(negedge clk_i);
        n_tests++;
        if (memory_ready_o !== 1'b1 || dmem_req_o !== 1'b0 || M_valM_o !== 32'h0) begin
            n_fail++;
            $display("FAIL alu_passthrough: ready=%b req=%b valM=%h, required 1 0 0",
                     memory_ready_o, dmem_req_o, M_valM_o);
        end
        @(posedge clk_i); #1;
        execute_vaild_i = 1'b0; ED_mem_rd_i = 1'b1;
        @(negedge clk_i);
        n_tests++;
        if (memory_ready_o !== 1'b1 || dmem_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL invalid_load: ready=%b req=%b, required 1 0", memory_ready_o, dmem_req_o);
        end
        @(posedge clk_i); #1;
        ED_mem_rd_i = 1'b0;
    endtask

    task automatic test_lw();
        run_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, 2, 32'hDEAD_BEEF, 0);
        n_tests++;
        if (obs_timeout || obs_first_req !== 1'b1 || obs_lat != 3 || obs_valM !== 32'hDEAD_BEEF ||
            obs_addr !== 32'h100 || obs_we !== 1'b0 || obs_nreq != 1) begin
            n_fail++;
            $display("FAIL lw_basic: to=%0d req0=%b lat=%0d valM=%h addr=%h we=%b nreq=%0d, required 0 1 3 deadbeef 00000100 0 1",
                     obs_timeout, obs_first_req, obs_lat, obs_valM, obs_addr, obs_we, obs_nreq);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  ops [3] = '{3'b000, 3'b100, 3'b101};
        logic [31:0] adr [3] = '{32'h103, 32'h103, 32'h102};
        logic [31:0] req [3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_80FF};
        for (int i = 0; i < 3; i++) begin
            run_op(1'b1, 1'b0, ops[i], adr[i], 32'h0, 1, 1, 32'h80FF_1234, 0);
            n_tests++;
            if (obs_timeout || obs_valM !== req[i] || obs_addr !== 32'h100) begin
                n_fail++;
                $display("FAIL load_ext_%0d: valM=%h addr=%h to=%0d, required %h 00000100",
                         i, obs_valM, obs_addr, obs_timeout, req[i]);
            end
        end
`ifndef MISALIGN_TRAP_EN
        // misaligned offsets fall back to natural alignment
        run_op(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 0, 1, 32'h1122_3344, 0);
        n_tests++;
        if (obs_timeout || obs_valM !== 32'h1122_3344) begin
            n_fail++;
            $display("FAIL lw_unaligned_nat: valM=%h, required 11223344", obs_valM);
        end
        run_op(1'b1, 1'b0, 3'b001, 32'h103, 32'h0, 0, 1, 32'hAABB_8001, 0);
        n_tests++;
        if (obs_timeout || obs_valM !== 32'hFFFF_AABB) begin
            n_fail++;
            $display("FAIL lh_unaligned_nat: valM=%h, required ffffaabb", obs_valM);
        end
`endif
    endtask

    task automatic test_sh();
        run_op(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 1, 1, 32'hFFFF_FFFF, 0);
        n_tests++;
        if (obs_timeout || obs_we !== 1'b1 || obs_strb !== 4'b1100 || obs_wdata !== 32'hABCD_ABCD ||
            obs_addr !== 32'h200 || obs_valM !== 32'h0 || obs_lat != 3) begin
            n_fail++;
            $display("FAIL sh_basic: we=%b strb=%b wdata=%h addr=%h valM=%h lat=%0d, required 1 1100 abcdabcd 00000200 0 3",
                     obs_we, obs_strb, obs_wdata, obs_addr, obs_valM, obs_lat);
        end
    endtask

    task automatic test_stall_hold();
        logic [31:0] d;
        d = $urandom;
        run_op(1'b1, 1'b0, 3'b010, 32'h344, 32'h0, 4, 1, d, 3);
        n_tests++;
        if (obs_timeout || obs_nreq != 5 || !obs_req_stable || obs_addr !== 32'h344) begin
            n_fail++;
            $display("FAIL gnt_stall: nreq=%0d stable=%0d addr=%h, required 5 1 00000344",
                     obs_nreq, obs_req_stable, obs_addr);
        end
        n_tests++;
        if (obs_lat != 6 || obs_valM !== d || !obs_hold_stable) begin
            n_fail++;
            $display("FAIL done_hold: lat=%0d valM=%h stable=%0d, required 6 %h 1",
                     obs_lat, obs_valM, obs_hold_stable, d);
        end
    endtask

    task automatic test_rst_in_wait();
        execute_vaild_i = 1'b1; ED_mem_rd_i = 1'b1; ED_mem_wr_i = 1'b0;
        ED_mem_op_i = 3'b010; ED_valE_i = 32'h80; write_back_allow_in_i = 1'b0;
        @(negedge clk_i);
        dmem_gnt_i = 1'b1;
        @(posedge clk_i); #1 dmem_gnt_i = 1'b0;
        @(negedge clk_i);
        n_tests++;
        if (memory_ready_o !== 1'b0 || dmem_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_state: ready=%b req=%b, required 0 0", memory_ready_o, dmem_req_o);
        end
        rst = 1'b1;
        @(posedge clk_i); #1;
        rst = 1'b0; execute_vaild_i = 1'b0; ED_mem_rd_i = 1'b0;
        @(negedge clk_i);
        n_tests++;
        if (memory_ready_o !== 1'b1 || dmem_req_o !== 1'b0 || M_valM_o !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_in_wait: ready=%b req=%b valM=%h, required 1 0 0",
                     memory_ready_o, dmem_req_o, M_valM_o);
        end
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hBAD0_BAD0;
        @(posedge clk_i); #1 dmem_rvalid_i = 1'b0;
        @(negedge clk_i);
        n_tests++;
        if (memory_ready_o !== 1'b1 || M_valM_o !== 32'h0 || dmem_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_rvalid: ready=%b valM=%h req=%b, required 1 0 0",
                     memory_ready_o, M_valM_o, dmem_req_o);
        end
        run_op(1'b1, 1'b0, 3'b010, 32'h84, 32'h0, 0, 1, 32'h1357_9BDF, 0);
        n_tests++;
        if (obs_timeout || obs_lat != 2 || obs_valM !== 32'h1357_9BDF) begin
            n_fail++;
            $display("FAIL after_rst_load: lat=%0d valM=%h, required 2 13579bdf", obs_lat, obs_valM);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ld_ops [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic [2:0]  op;
        logic [31:0] a, d, r;
        bit          is_ld;
        int          g, v;
        for (int i = 0; i < 40; i++) begin
            is_ld = $urandom_range(0, 1) == 1;
            op = is_ld ? ld_ops[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
            a = $urandom; d = $urandom; r = $urandom;
            g = $urandom_range(0, 3); v = $urandom_range(1, 3);
`ifdef MISALIGN_TRAP_EN
            a = a - 32'(eff_off(op, a) == 0 ? (a % 4) % access_size(op) : a % 4);
            a = a - (a % 32'(access_size(op)));
`endif
            run_op(is_ld, !is_ld, op, a, d, g, v, r, $urandom_range(0, 2));
            n_tests++;
            if (obs_timeout || obs_lat != g + v + 1 || obs_nreq != g + 1 || !obs_req_stable ||
                !obs_hold_stable || obs_addr !== (a & 32'hFFFF_FFFC) || obs_we !== !is_ld ||
                obs_valM !== (is_ld ? exp_load(op, a, r) : 32'h0) ||
                (!is_ld && (obs_strb !== exp_strb(op, a) || obs_wdata !== exp_wdata(op, d)))) begin
                n_fail++;
                $display("FAIL rand_%0d: op=%b ld=%0d a=%h lat=%0d nreq=%0d valM=%h strb=%b wdata=%h, required lat=%0d nreq=%0d valM=%h strb=%b wdata=%h",
                         i, op, is_ld, a, obs_lat, obs_nreq, obs_valM, obs_strb, obs_wdata,
                         g + v + 1, g + 1, is_ld ? exp_load(op, a, r) : 32'h0,
                         exp_strb(op, a), exp_wdata(op, d));
            end
        end
    endtask

`ifdef MISALIGN_TRAP_EN
    task automatic test_misalign();
        run_op(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 0, 1, 32'hFFFF_FFFF, 0);
        n_tests++;
        if (obs_timeout || obs_nreq != 0 || obs_lat != 1 || obs_mis !== 1'b1 || obs_valM !== 32'h0) begin
            n_fail++;
            $display("FAIL misalign_lw: nreq=%0d lat=%0d mis=%b valM=%h, required 0 1 1 0",
                     obs_nreq, obs_lat, obs_mis, obs_valM);
        end
        @(negedge clk_i);
        n_tests++;
        if (M_misalign_o !== 1'b0) begin
            n_fail++;
            $display("FAIL misalign_clear: mis=%b, required 0", M_misalign_o);
        end
        run_op(1'b0, 1'b1, 3'b001, 32'h203, 32'h55AA, 0, 1, 32'h0, 0);
        n_tests++;
        if (obs_timeout || obs_nreq != 0 || obs_mis !== 1'b1) begin
            n_fail++;
            $display("FAIL misalign_sh: nreq=%0d mis=%b, required 0 1", obs_nreq, obs_mis);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        execute_vaild_i = 1'b0; ED_mem_rd_i = 1'b0; ED_mem_wr_i = 1'b0;
        ED_mem_op_i = 3'b000; ED_valE_i = '0; ED_valB_i = '0;
        write_back_allow_in_i = 1'b0;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
        test_reset();
        test_passthrough();
        test_lw();
        test_loads();
        test_sh();
        test_stall_hold();
        test_rst_in_wait();
        test_back_to_back();
`ifdef MISALIGN_TRAP_EN
        test_misalign();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
